// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: debounce scheduler for a bank of active-low push keys.
// One timer is shared by all keys. Falling edges are latched as pending
// requests and served one at a time in round-robin order. A served press
// is confirmed or discarded, then classified as short or long. The result
// leaves on a valid/ready event port, and an accepted short press toggles
// that key's LED.
module key_scan_ctrl #(
    parameter int N_KEYS      = 4,
    parameter int DEB_CYCLES  = 10,
    parameter int LONG_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_KEYS-1:0]         i_key_n,
    input  logic                      i_evt_ready,
    output logic                      o_evt_valid,
    output logic [$clog2(N_KEYS)-1:0] o_evt_key,
    output logic                      o_evt_long,
    output logic [N_KEYS-1:0]         o_led,
    output logic                      o_busy
);

    localparam int KW = $clog2(N_KEYS);
    localparam int CW = $clog2(LONG_CYCLES + 1);

    localparam logic [CW-1:0] DEB_C  = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] HOLD_C = CW'(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LONG_C = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEB      = 3'd1,
        ST_SAMPLE   = 3'd2,
        ST_HOLD     = 3'd3,
        ST_EMIT     = 3'd4,
        ST_WAIT_REL = 3'd5
    } state_t;

    // synchroniser chain; s3 only serves edge detection
    logic [N_KEYS-1:0] r_s1, r_s2, r_s3;
    logic [N_KEYS-1:0] r_pend;

    state_t            r_state;
    logic [KW-1:0]     r_grant;
    logic [KW-1:0]     r_rr_ptr;
    logic [CW-1:0]     r_cnt;
    logic              r_evt_valid;
    logic [KW-1:0]     r_evt_key;
    logic              r_evt_long;
    logic [N_KEYS-1:0] r_led;
    logic              r_busy;

    logic [N_KEYS-1:0] w_fall;
    logic [N_KEYS-1:0] w_set;
    logic [N_KEYS-1:0] w_clr;
    logic              w_pick_vld;
    logic [KW-1:0]     w_pick;
    int                w_idx;
    logic [CW-1:0]     w_cnt_inc;
    logic              w_rel;

    assign w_fall    = ~r_s2 & r_s3;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + ONE_C;
    assign w_rel     = r_s2[r_grant];

    // two-flop synchroniser plus history flop, released (1) after reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1 <= '1;
            r_s2 <= '1;
            r_s3 <= '1;
        end else begin
            r_s1 <= i_key_n;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // round-robin pick: first pending key after rr_ptr; smallest offset wins
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        w_idx      = 0;
        for (int k = N_KEYS; k >= 1; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N_KEYS) w_idx = w_idx - N_KEYS;
            if (r_pend[w_idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = KW'(w_idx);
            end
        end
    end

    // pending set/clear masks; an edge on the key in service is ignored
    always_comb begin
        w_set = w_fall;
        w_clr = '0;
        if (r_state != ST_IDLE) w_set[r_grant] = 1'b0;
        if (r_state == ST_IDLE && w_pick_vld) w_clr[w_pick] = 1'b1;
    end

    // pending request register; clear has priority over a same-cycle set
    always_ff @(posedge clk) begin
        if (!rst) r_pend <= '0;
        else      r_pend <= (r_pend | w_set) & ~w_clr;
    end

    // service FSM with registered event, LED and busy outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= KW'(N_KEYS - 1);
            r_cnt       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_key   <= '0;
            r_evt_long  <= 1'b0;
            r_led       <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant  <= w_pick;
                        r_rr_ptr <= w_pick;
                        r_cnt    <= ONE_C;
                        r_busy   <= 1'b1;
                        r_state  <= ST_DEB;
                    end
                end
                ST_DEB: begin
                    if (r_cnt >= DEB_C) r_state <= ST_SAMPLE;
                    else                r_cnt   <= w_cnt_inc;
                end
                ST_SAMPLE: begin
                    if (w_rel) begin
                        // bounce or glitch: drop without an event
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= HOLD_C;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_rel) begin
                        r_evt_valid <= 1'b1;
                        r_evt_key   <= r_grant;
                        r_evt_long  <= 1'b0;
                        r_state     <= ST_EMIT;
                    end else if (r_cnt >= LONG_C) begin
                        // long press is reported without waiting for release
                        r_evt_valid <= 1'b1;
                        r_evt_key   <= r_grant;
                        r_evt_long  <= 1'b1;
                        r_state     <= ST_EMIT;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_EMIT: begin
                    if (i_evt_ready) begin
                        r_evt_valid <= 1'b0;
                        if (r_evt_long) begin
                            r_state <= ST_WAIT_REL;
                        end else begin
                            r_led[r_grant] <= ~r_led[r_grant];
                            r_busy         <= 1'b0;
                            r_state        <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_REL: begin
                    if (w_rel) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_evt_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_evt_valid = r_evt_valid;
    assign o_evt_key   = r_evt_key;
    assign o_evt_long  = r_evt_long;
    assign o_led       = r_led;
    assign o_busy      = r_busy;

endmodule
